// File: rtl/rx_frame_sequencer.sv
// rx_frame_sequencer
// Receive-side frame sequencer for the 10G MAC rx engine. It follows each frame
// from start-of-frame to terminator, counts 64-bit data words in frame_cnt for
// the length/type checker, waits out the checker pipeline, then issues exactly
// one good_frame or bad_frame strobe with a reason code in frame_status.
//
// Optional feature: define RX_FRAME_STATS_EN to build the saturating 16-bit
// good/bad frame statistics counters. Without it good_count and bad_count are
// tied to zero.
module rx_frame_sequencer #(
    parameter int TP    = 1,
    parameter int CNT_W = 12
) (
    input  logic             rxclk,
    input  logic             reset,
    input  logic             start_da,
    input  logic             data_valid,
    input  logic             get_terminator,
    input  logic [2:0]       terminator_location,
    input  logic             code_error,
    input  logic             length_error,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             frame_busy,
    output logic             good_frame,
    output logic             bad_frame,
    output logic [2:0]       frame_status,
    output logic [15:0]      good_count,
    output logic [15:0]      bad_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_CHK1,
        S_CHK2,
        S_REPORT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [2:0] ST_GOOD   = 3'd0;
    localparam logic [2:0] ST_LENGTH = 3'd1;
    localparam logic [2:0] ST_CODE   = 3'd2;
    localparam logic [2:0] ST_TRUNC  = 3'd3;

    state_t           r_state;
    logic [CNT_W-1:0] r_frame_cnt;
    logic             r_frame_busy;
    logic             r_good_frame;
    logic             r_bad_frame;
    logic [2:0]       r_frame_status;
    logic             r_code_err;

    // terminator_location only passes by on its way to the checker, and TP is a
    // simulation-delay parameter with no meaning in synthesizable logic.
    logic w_unused;
    assign w_unused = ^{terminator_location, 1'(TP)};

    // Frame state machine: word counting, sticky code error and the report strobe.
    always_ff @(posedge rxclk) begin
        // NOTE: reset is sampled on the clock edge, so it sits inside the
        // clocked block rather than in the sensitivity list.
        if (!reset) begin
            r_state        <= S_IDLE;
            r_frame_cnt    <= '0;
            r_frame_busy   <= 1'b0;
            r_good_frame   <= 1'b0;
            r_bad_frame    <= 1'b0;
            r_frame_status <= ST_GOOD;
            r_code_err     <= 1'b0;
        end else begin
            // NOTE: strobes default low every cycle so they last exactly one
            // cycle; all state uses non-blocking assignment so every branch
            // sees the pre-edge values.
            r_good_frame <= 1'b0;
            r_bad_frame  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    // The start_da word is the first data word of the frame.
                    if (start_da) begin
                        r_frame_cnt  <= {{(CNT_W-1){1'b0}}, data_valid};
                        r_code_err   <= 1'b0;
                        r_frame_busy <= 1'b1;
                        r_state      <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (get_terminator) begin
                        // Terminator word is not counted; frame_cnt freezes here.
                        if (code_error) begin
                            r_code_err <= 1'b1;
                        end
                        r_state <= S_CHK1;
                    end else if (start_da) begin
                        // A new start before the terminator truncates this frame;
                        // the new frame is dropped.
                        r_bad_frame    <= 1'b1;
                        r_frame_status <= ST_TRUNC;
                        r_state        <= S_REPORT;
                    end else begin
                        if (data_valid && (r_frame_cnt != CNT_MAX)) begin
                            r_frame_cnt <= r_frame_cnt + 1'b1;
                        end
                        if (code_error) begin
                            r_code_err <= 1'b1;
                        end
                    end
                end

                S_CHK1: begin
                    // Checker captures the terminator location this cycle.
                    r_state <= S_CHK2;
                end

                S_CHK2: begin
                    // length_error is valid at the end of this cycle.
                    r_state <= S_REPORT;
                    if (r_code_err) begin
                        r_bad_frame    <= 1'b1;
                        r_frame_status <= ST_CODE;
                    end else if (length_error) begin
                        r_bad_frame    <= 1'b1;
                        r_frame_status <= ST_LENGTH;
                    end else begin
                        r_good_frame   <= 1'b1;
                        r_frame_status <= ST_GOOD;
                    end
                end

                S_REPORT: begin
                    r_frame_busy   <= 1'b0;
                    r_frame_status <= ST_GOOD;
                    r_state        <= S_IDLE;
                end

                default: begin
                    r_frame_busy <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign frame_cnt    = r_frame_cnt;
    assign frame_busy   = r_frame_busy;
    assign good_frame   = r_good_frame;
    assign bad_frame    = r_bad_frame;
    assign frame_status = r_frame_status;

`ifdef RX_FRAME_STATS_EN
    logic [15:0] r_good_count;
    logic [15:0] r_bad_count;

    // Saturating frame statistics, bumped on the report strobe.
    always_ff @(posedge rxclk) begin
        if (!reset) begin
            r_good_count <= '0;
            r_bad_count  <= '0;
        end else if (r_state == S_REPORT) begin
            if (r_good_frame && (r_good_count != 16'hFFFF)) begin
                r_good_count <= r_good_count + 16'd1;
            end
            if (r_bad_frame && (r_bad_count != 16'hFFFF)) begin
                r_bad_count <= r_bad_count + 16'd1;
            end
        end
    end

    assign good_count = r_good_count;
    assign bad_count  = r_bad_count;
`else
    assign good_count = '0;
    assign bad_count  = '0;
`endif

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// Self-checking bench for rx_frame_sequencer. Frames are described at the
// level of "n data words, code error at word k, length error yes/no,
// truncated yes/no"; the expected count, reason code and statistics come
// from those descriptions alone.
module tb_rx_frame_sequencer;

    localparam int CNT_W   = 12;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             rxclk = 1'b0;
    logic             reset = 1'b0;
    logic             start_da = 1'b0;
    logic             data_valid = 1'b0;
    logic             get_terminator = 1'b0;
    logic [2:0]       terminator_location = 3'd0;
    logic             code_error = 1'b0;
    logic             length_error = 1'b0;
    logic [CNT_W-1:0] frame_cnt;
    logic             frame_busy;
    logic             good_frame;
    logic             bad_frame;
    logic [2:0]       frame_status;
    logic [15:0]      good_count;
    logic [15:0]      bad_count;

    rx_frame_sequencer #(.TP(1), .CNT_W(CNT_W)) dut (
        .rxclk               (rxclk),
        .reset               (reset),
        .start_da            (start_da),
        .data_valid          (data_valid),
        .get_terminator      (get_terminator),
        .terminator_location (terminator_location),
        .code_error          (code_error),
        .length_error        (length_error),
        .frame_cnt           (frame_cnt),
        .frame_busy          (frame_busy),
        .good_frame          (good_frame),
        .bad_frame           (bad_frame),
        .frame_status        (frame_status),
        .good_count          (good_count),
        .bad_count           (bad_count)
    );

    always #5 rxclk = ~rxclk;

    int n_cmp = 0;
    int n_err = 0;

    // Strobe monitor, sampled on the falling edge.
    int n_good_seen = 0;
    int n_bad_seen  = 0;
    int n_both_seen = 0;
    always @(negedge rxclk) begin
        if (good_frame) n_good_seen++;
        if (bad_frame)  n_bad_seen++;
        if (good_frame && bad_frame) n_both_seen++;
    end

    // Reference statistics since the last reset.
    int exp_good = 0;
    int exp_bad  = 0;

    // Observations gathered by the frame drivers.
    int         obs_cnt;
    int         obs_cnt_end;
    logic       obs_good;
    logic       obs_bad;
    logic [2:0] obs_status;
    logic       obs_busy_data;
    logic       obs_busy_report;
    logic       obs_busy_after;
    logic       obs_early;
    logic       obs_late;

    function automatic int exp_cnt(input int n_words);
        return (n_words > CNT_MAX) ? CNT_MAX : n_words;
    endfunction

    function automatic int exp_status(input int code_pos, input bit len_err, input bit trunc);
        if (trunc)         return 3;
        if (code_pos >= 1) return 2;
        if (len_err)       return 1;
        return 0;
    endfunction

    function automatic int stat_exp(input int n);
`ifdef RX_FRAME_STATS_EN
        return (n > 65535) ? 65535 : n;
`else
        return 0;
`endif
    endfunction

    task automatic step();
        @(posedge rxclk);
        #1;
    endtask

    task automatic idle_inputs();
        reset          = 1'b1;
        start_da       = 1'b0;
        data_valid     = 1'b0;
        get_terminator = 1'b0;
        code_error     = 1'b0;
        length_error   = 1'b0;
    endtask

    // Drives one complete frame: start word, n_words-1 further data words with
    // optional idle gaps, terminator, then the three check/report cycles.
    // code_pos in 1..n_words marks a code error (n_words = terminator cycle).
    task automatic drive_frame(input int n_words, input int code_pos, input bit len_err,
                               input bit len_noise, input bit ign_start, input int gap_pct);
        idle_inputs();
        start_da   = 1'b1;
        data_valid = 1'b1;
        step();
        start_da      = 1'b0;
        obs_busy_data = frame_busy;
        for (int i = 1; i < n_words; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                data_valid   = 1'b0;
                code_error   = 1'b0;
                length_error = len_noise & 1'($urandom_range(1));
                step();
            end
            data_valid   = 1'b1;
            code_error   = (i == code_pos);
            length_error = len_noise & 1'($urandom_range(1));
            step();
        end
        data_valid          = 1'b1;
        get_terminator      = 1'b1;
        terminator_location = 3'($urandom);
        code_error          = (code_pos == n_words);
        length_error        = 1'b0;
        step();
        obs_cnt   = int'(frame_cnt);
        obs_early = good_frame | bad_frame;
        // CHK1
        idle_inputs();
        start_da     = ign_start;
        data_valid   = ign_start;
        length_error = len_noise;
        step();
        obs_early = obs_early | good_frame | bad_frame;
        // CHK2
        start_da     = ign_start;
        data_valid   = ign_start;
        length_error = len_err;
        step();
        obs_good        = good_frame;
        obs_bad         = bad_frame;
        obs_status      = frame_status;
        obs_busy_report = frame_busy;
        // REPORT
        start_da     = ign_start;
        data_valid   = ign_start;
        length_error = len_noise;
        step();
        obs_busy_after = frame_busy;
        obs_late       = good_frame | bad_frame;
        obs_cnt_end    = int'(frame_cnt);
        idle_inputs();
        if (exp_status(code_pos, len_err, 1'b0) == 0) exp_good++;
        else exp_bad++;
    endtask

    // Drives k data words (start word included) then a second start_da
    // without a terminator.
    task automatic drive_trunc(input int k);
        idle_inputs();
        start_da   = 1'b1;
        data_valid = 1'b1;
        step();
        start_da      = 1'b0;
        obs_busy_data = frame_busy;
        for (int i = 1; i < k; i++) begin
            data_valid = 1'b1;
            step();
        end
        data_valid = 1'b0;
        start_da   = 1'b1;
        step();
        obs_good        = good_frame;
        obs_bad         = bad_frame;
        obs_status      = frame_status;
        obs_busy_report = frame_busy;
        obs_cnt         = int'(frame_cnt);
        idle_inputs();
        step();
        obs_busy_after = frame_busy;
        obs_late       = good_frame | bad_frame;
        obs_cnt_end    = int'(frame_cnt);
        exp_bad++;
    endtask

    task automatic test_reset();
        reset          = 1'b0;
        start_da       = 1'b1;
        data_valid     = 1'b1;
        code_error     = 1'b1;
        get_terminator = 1'b0;
        repeat (3) step();
        exp_good = 0;
        exp_bad  = 0;
        n_cmp++;
        if ({frame_cnt, frame_busy, good_frame, bad_frame, frame_status, good_count, bad_count} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got cnt=%0d busy=%b good=%b bad=%b status=%0d gc=%0d bc=%0d expected all zero",
                     frame_cnt, frame_busy, good_frame, bad_frame, frame_status, good_count, bad_count);
        end
        idle_inputs();
        step();
        n_cmp++;
        if (frame_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release_busy: got %b expected 0", frame_busy);
        end
    endtask

    task automatic test_normal();
        drive_frame(8, -1, 1'b0, 1'b0, 1'b0, 0);
        n_cmp++;
        if (obs_cnt !== 8) begin n_err++; $display("FAIL normal_cnt: got %0d expected 8", obs_cnt); end
        n_cmp++;
        if ({obs_good, obs_bad, obs_status} !== {1'b1, 1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL normal_strobe: got good=%b bad=%b status=%0d expected good=1 bad=0 status=0",
                     obs_good, obs_bad, obs_status);
        end
        n_cmp++;
        if ({obs_busy_data, obs_busy_report, obs_busy_after} !== 3'b110) begin
            n_err++;
            $display("FAIL normal_busy: got data/report/after=%b%b%b expected 110",
                     obs_busy_data, obs_busy_report, obs_busy_after);
        end
        n_cmp++;
        if ({obs_early, obs_late} !== 2'b00) begin
            n_err++;
            $display("FAIL normal_strobe_timing: got early=%b late=%b expected 0 0", obs_early, obs_late);
        end
        n_cmp++;
        if (obs_cnt_end !== 8) begin n_err++; $display("FAIL normal_cnt_hold: got %0d expected 8", obs_cnt_end); end
    endtask

    task automatic test_length_error();
        drive_frame(8, -1, 1'b1, 1'b0, 1'b0, 10);
        n_cmp++;
        if ({obs_good, obs_bad, obs_status} !== {1'b0, 1'b1, 3'd1}) begin
            n_err++;
            $display("FAIL length_err: got good=%b bad=%b status=%0d expected good=0 bad=1 status=1",
                     obs_good, obs_bad, obs_status);
        end
        drive_frame(6, -1, 1'b0, 1'b1, 1'b0, 0);
        n_cmp++;
        if ({obs_good, obs_bad, obs_status} !== {1'b1, 1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL length_outside_chk2: got good=%b bad=%b status=%0d expected good=1 bad=0 status=0",
                     obs_good, obs_bad, obs_status);
        end
    endtask

    task automatic test_code_error();
        drive_frame(8, 3, 1'b0, 1'b0, 1'b0, 0);
        n_cmp++;
        if ({obs_good, obs_bad, obs_status} !== {1'b0, 1'b1, 3'd2}) begin
            n_err++;
            $display("FAIL code_err: got good=%b bad=%b status=%0d expected good=0 bad=1 status=2",
                     obs_good, obs_bad, obs_status);
        end
        // Code error on the terminator word, together with a length error.
        drive_frame(5, 5, 1'b1, 1'b0, 1'b0, 0);
        n_cmp++;
        if ({obs_good, obs_bad, obs_status} !== {1'b0, 1'b1, 3'd2}) begin
            n_err++;
            $display("FAIL code_err_at_term: got good=%b bad=%b status=%0d expected good=0 bad=1 status=2",
                     obs_good, obs_bad, obs_status);
        end
    endtask

    task automatic test_truncation();
        int good0;
        int bad0;
        drive_trunc(5);
        n_cmp++;
        if ({obs_good, obs_bad, obs_status} !== {1'b0, 1'b1, 3'd3}) begin
            n_err++;
            $display("FAIL trunc_strobe: got good=%b bad=%b status=%0d expected good=0 bad=1 status=3",
                     obs_good, obs_bad, obs_status);
        end
        n_cmp++;
        if (obs_cnt !== 5) begin n_err++; $display("FAIL trunc_cnt: got %0d expected 5", obs_cnt); end
        n_cmp++;
        if ({obs_busy_report, obs_busy_after, obs_late} !== 3'b100) begin
            n_err++;
            $display("FAIL trunc_busy: got report/after/late=%b%b%b expected 100",
                     obs_busy_report, obs_busy_after, obs_late);
        end
        // Remainder of the dropped frame arrives while idle.
        good0 = n_good_seen;
        bad0  = n_bad_seen;
        data_valid = 1'b1;
        code_error = 1'b1;
        repeat (3) step();
        get_terminator = 1'b1;
        step();
        idle_inputs();
        repeat (5) step();
        n_cmp++;
        if ((n_good_seen - good0) + (n_bad_seen - bad0) !== 0) begin
            n_err++;
            $display("FAIL trunc_dropped_strobes: got %0d expected 0", (n_good_seen - good0) + (n_bad_seen - bad0));
        end
        n_cmp++;
        if ({frame_cnt, frame_busy} !== {12'd5, 1'b0}) begin
            n_err++;
            $display("FAIL trunc_dropped_state: got cnt=%0d busy=%b expected cnt=5 busy=0", frame_cnt, frame_busy);
        end
    endtask

    task automatic test_saturation();
        drive_frame(4100, -1, 1'b0, 1'b0, 1'b0, 0);
        n_cmp++;
        if (obs_cnt !== CNT_MAX) begin n_err++; $display("FAIL sat_cnt: got %0d expected %0d", obs_cnt, CNT_MAX); end
        n_cmp++;
        if ({obs_good, obs_bad} !== 2'b10) begin
            n_err++;
            $display("FAIL sat_strobe: got good=%b bad=%b expected good=1 bad=0", obs_good, obs_bad);
        end
    endtask

    task automatic test_back_to_back();
        // start_da at T+1, T+2 and T+3 must be ignored.
        drive_frame(4, -1, 1'b0, 1'b0, 1'b1, 0);
        n_cmp++;
        if ({obs_good, obs_busy_after, obs_early, obs_late} !== 4'b1000) begin
            n_err++;
            $display("FAIL b2b_dropped: got good/busy_after/early/late=%b%b%b%b expected 1000",
                     obs_good, obs_busy_after, obs_early, obs_late);
        end
        // Next frame starts right away at T+4 and must be accepted.
        drive_frame(3, -1, 1'b0, 1'b0, 1'b0, 0);
        n_cmp++;
        if ({obs_busy_data, obs_good} !== 2'b11 || obs_cnt !== 3) begin
            n_err++;
            $display("FAIL b2b_accept: got busy=%b good=%b cnt=%0d expected busy=1 good=1 cnt=3",
                     obs_busy_data, obs_good, obs_cnt);
        end
    endtask

    task automatic test_random();
        int n;
        int cpos;
        bit len;
        int es;
        for (int f = 0; f < 30; f++) begin
            n = int'($urandom_range(1, 20));
            if ($urandom_range(4) == 0) begin
                drive_trunc(n);
                es   = 3;
                cpos = -1;
            end else begin
                cpos = ($urandom_range(2) == 0) ? int'($urandom_range(1, n)) : -1;
                len  = 1'($urandom_range(1));
                drive_frame(n, cpos, len, 1'($urandom_range(1)), 1'($urandom_range(1)), 25);
                es = exp_status(cpos, len, 1'b0);
            end
            n_cmp++;
            if (obs_cnt !== exp_cnt(n) || obs_cnt_end !== exp_cnt(n)) begin
                n_err++;
                $display("FAIL rand_cnt[%0d]: got %0d/%0d expected %0d", f, obs_cnt, obs_cnt_end, exp_cnt(n));
            end
            n_cmp++;
            if ({obs_good, obs_bad, obs_status} !== {(es == 0), (es != 0), 3'(es)}) begin
                n_err++;
                $display("FAIL rand_report[%0d]: got good=%b bad=%b status=%0d expected status=%0d",
                         f, obs_good, obs_bad, obs_status, es);
            end
            n_cmp++;
            if ({obs_busy_data, obs_busy_report, obs_busy_after, obs_late} !== 4'b1100) begin
                n_err++;
                $display("FAIL rand_busy[%0d]: got data/report/after/late=%b%b%b%b expected 1100",
                         f, obs_busy_data, obs_busy_report, obs_busy_after, obs_late);
            end
        end
        n_cmp++;
        if (int'(good_count) !== stat_exp(exp_good) || int'(bad_count) !== stat_exp(exp_bad)) begin
            n_err++;
            $display("FAIL rand_stats: got good=%0d bad=%0d expected good=%0d bad=%0d",
                     good_count, bad_count, stat_exp(exp_good), stat_exp(exp_bad));
        end
    endtask

    task automatic test_reset_mid_data();
        int good0;
        int bad0;
        idle_inputs();
        start_da   = 1'b1;
        data_valid = 1'b1;
        step();
        start_da = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();
        exp_good = 0;
        exp_bad  = 0;
        n_cmp++;
        if ({frame_cnt, frame_busy, good_frame, bad_frame, good_count, bad_count} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_data: got cnt=%0d busy=%b good=%b bad=%b gc=%0d bc=%0d expected all zero",
                     frame_cnt, frame_busy, good_frame, bad_frame, good_count, bad_count);
        end
        good0 = n_good_seen;
        bad0  = n_bad_seen;
        idle_inputs();
        data_valid     = 1'b1;
        get_terminator = 1'b1;
        step();
        idle_inputs();
        repeat (5) step();
        n_cmp++;
        if ((n_good_seen - good0) + (n_bad_seen - bad0) !== 0 || frame_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_strobe: got strobes=%0d busy=%b expected 0 0",
                     (n_good_seen - good0) + (n_bad_seen - bad0), frame_busy);
        end
    endtask

    task automatic test_stats();
        idle_inputs();
        reset = 1'b0;
        step();
        exp_good = 0;
        exp_bad  = 0;
        idle_inputs();
        step();
        drive_frame(4, -1, 1'b0, 1'b0, 1'b0, 0);
        drive_frame(5, 2, 1'b0, 1'b0, 1'b0, 0);
        drive_frame(6, -1, 1'b0, 1'b0, 1'b0, 10);
        drive_frame(3, -1, 1'b1, 1'b0, 1'b0, 0);
        drive_frame(7, -1, 1'b0, 1'b0, 1'b0, 0);
        n_cmp++;
        if (int'(good_count) !== stat_exp(3)) begin
            n_err++;
            $display("FAIL stats_good: got %0d expected %0d", good_count, stat_exp(3));
        end
        n_cmp++;
        if (int'(bad_count) !== stat_exp(2)) begin
            n_err++;
            $display("FAIL stats_bad: got %0d expected %0d", bad_count, stat_exp(2));
        end
    endtask

    task automatic test_exclusive();
        n_cmp++;
        if (n_both_seen !== 0) begin
            n_err++;
            $display("FAIL strobe_exclusive: got %0d overlapping cycles expected 0", n_both_seen);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete within the time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_normal();
        test_length_error();
        test_code_error();
        test_truncation();
        test_saturation();
        test_back_to_back();
        test_random();
        test_reset_mid_data();
        test_stats();
        test_exclusive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
